descpt_feeder: RTL and testbench

- Responder side of the matcher's descriptor_request / descriptor_valid handshake.
- Serves image descriptors in groups of four.
- On each request it fetches the next four 403-bit R/C/descriptor words from the image descriptor memory (sync-read, 1-cycle latency) into four holding registers. It then pulses descriptor_valid.
- The matcher reads image_R_C_D_0..3 combinationally for a whole target sweep, so the holding registers change only during a fetch.

---
 rtl/match_pkg.sv | 11 +
 rtl/descpt_feeder.sv | 168 ++++++++++++++++
 tb/tb_descpt_feeder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Constants shared between the descriptor matcher and its descriptor feeder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package match_pkg;

    localparam int MATCH_DESC_W = 403;  // one row/col/descriptor word
    localparam int MATCH_ADDR_W = 12;   // descriptor memory address width
    localparam int MATCH_CNT_W  = 11;   // per-layer descriptor count width
    localparam int GROUP_SIZE   = 4;    // descriptors served per request

endpackage

// File: rtl/descpt_feeder.sv
// Purpose: answers the matcher's descriptor_request by loading the next group of four
//          descriptors from a sync-read memory into holding registers, then pulsing descriptor_valid.
// Latency: request seen in c0 -> descriptor_valid in c6 (c1 when no descriptors remain); busy RD0..LAST.
// Ports: clk/rst_n, start + layer counts, request/valid handshake, four holding slots + slot_valid,
//        exhausted/busy status, memory read port (mem_en/mem_addr out, mem_dout in).
module descpt_feeder
    import match_pkg::*;
#(
    parameter int DESC_W = MATCH_DESC_W,
    parameter int ADDR_W = MATCH_ADDR_W,
    parameter int CNT_W  = MATCH_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      layer1_num,
    input  logic [CNT_W-1:0]      layer2_num,
    input  logic                  descriptor_request,
    output logic                  descriptor_valid,
    output logic [DESC_W-1:0]     image_R_C_D_0,
    output logic [DESC_W-1:0]     image_R_C_D_1,
    output logic [DESC_W-1:0]     image_R_C_D_2,
    output logic [DESC_W-1:0]     image_R_C_D_3,
    output logic [GROUP_SIZE-1:0] slot_valid,
    output logic                  exhausted,
    output logic                  busy,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DESC_W-1:0]     mem_dout
);

    localparam int TOT_W = CNT_W + 1;
    // Comparison width wide enough for base+3 and for total, so range checks never wrap.
    localparam int CMP_W = ((ADDR_W + 2) > TOT_W) ? (ADDR_W + 2) : TOT_W;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REQ, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_VALID
    } state_t;

    state_t                r_state;
    state_t                w_next;
    // One spare bit so base can step past the last group without wrapping back to 0.
    logic [ADDR_W:0]       r_base;
    logic [TOT_W-1:0]      r_total;
    logic                  r_exhausted;
    logic [DESC_W-1:0]     r_slot     [GROUP_SIZE];
    logic                  r_slot_vld [GROUP_SIZE];

    logic [GROUP_SIZE-1:0] w_in_range;  // bit k: base+k is a real descriptor
    logic [GROUP_SIZE-1:0] w_cap;       // bit k: capture mem_dout into slot k this edge
    logic                  w_rd;
    logic [1:0]            w_rd_idx;
    logic                  w_exh_hit;   // request arrived with nothing left

    for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_range
        assign w_in_range[k] = (CMP_W'(r_base) + CMP_W'(k)) < CMP_W'(r_total);
    end

    always_comb begin
        w_next    = r_state;
        w_rd      = 1'b0;
        w_rd_idx  = 2'd0;
        w_cap     = '0;
        w_exh_hit = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_WAIT_REQ: begin
                if (descriptor_request) begin
                    if (w_in_range[0]) begin
                        w_next = S_RD0;
                    end else begin
                        w_next    = S_VALID;
                        w_exh_hit = 1'b1;
                    end
                end
            end
            S_RD0: begin
                w_rd     = 1'b1;
                w_rd_idx = 2'd0;
                w_next   = S_RD1;
            end
            // Read data for RDk arrives one cycle later, so slot k loads at the end of the next state.
            S_RD1: begin
                w_rd     = 1'b1;
                w_rd_idx = 2'd1;
                w_cap[0] = 1'b1;
                w_next   = S_RD2;
            end
            S_RD2: begin
                w_rd     = 1'b1;
                w_rd_idx = 2'd2;
                w_cap[1] = 1'b1;
                w_next   = S_RD3;
            end
            S_RD3: begin
                w_rd     = 1'b1;
                w_rd_idx = 2'd3;
                w_cap[2] = 1'b1;
                w_next   = S_LAST;
            end
            S_LAST: begin
                w_cap[3] = 1'b1;
                w_next   = S_VALID;
            end
            S_VALID: w_next = S_WAIT_REQ;
            default: w_next = S_IDLE;
        endcase
        // start aborts any fetch; holding registers must keep their contents.
        if (start) begin
            w_next    = S_WAIT_REQ;
            w_cap     = '0;
            w_exh_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_total     <= '0;
            r_exhausted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (start) begin
                r_total     <= TOT_W'(layer1_num) + TOT_W'(layer2_num);
                r_base      <= '0;
                r_exhausted <= 1'b0;
            end else begin
                if (w_exh_hit) begin
                    r_exhausted <= 1'b1;
                end
                if (r_state == S_VALID && !r_exhausted) begin
                    r_base <= r_base + (ADDR_W + 1)'(GROUP_SIZE);
                end
            end
        end
    end

    for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot[k]     <= '0;
                r_slot_vld[k] <= 1'b0;
            end else if (w_exh_hit) begin
                r_slot[k]     <= '0;
                r_slot_vld[k] <= 1'b0;
            end else if (w_cap[k]) begin
                // Out-of-range slots were not read; load zero instead of stale memory output.
                r_slot[k]     <= w_in_range[k] ? mem_dout : '0;
                r_slot_vld[k] <= w_in_range[k];
            end
        end
        assign slot_valid[k] = r_slot_vld[k];
    end

    assign image_R_C_D_0    = r_slot[0];
    assign image_R_C_D_1    = r_slot[1];
    assign image_R_C_D_2    = r_slot[2];
    assign image_R_C_D_3    = r_slot[3];
    assign exhausted        = r_exhausted;
    assign descriptor_valid = (r_state == S_VALID);
    assign busy             = (r_state == S_RD0) || (r_state == S_RD1) || (r_state == S_RD2)
                           || (r_state == S_RD3) || (r_state == S_LAST);
    // Combinational from state so a reset drops the memory port immediately.
    assign mem_en           = w_rd && w_in_range[w_rd_idx];
    assign mem_addr         = w_rd ? (r_base[ADDR_W-1:0] + ADDR_W'(w_rd_idx)) : '0;

endmodule

// File: tb/tb_descpt_feeder.sv
module tb_descpt_feeder;
    import match_pkg::*;

    localparam int DESC_W = MATCH_DESC_W;
    localparam int ADDR_W = MATCH_ADDR_W;
    localparam int CNT_W  = MATCH_CNT_W;

    typedef struct packed {
        logic [3:0][DESC_W-1:0] d;
        logic [3:0]             sv;
        logic                   exh;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  layer1_num;
    logic [CNT_W-1:0]  layer2_num;
    logic              descriptor_request;
    logic              descriptor_valid;
    logic [DESC_W-1:0] image_R_C_D_0;
    logic [DESC_W-1:0] image_R_C_D_1;
    logic [DESC_W-1:0] image_R_C_D_2;
    logic [DESC_W-1:0] image_R_C_D_3;
    logic [3:0]        slot_valid;
    logic              exhausted;
    logic              busy;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DESC_W-1:0] mem_dout;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last_exp;
    int   m_base;
    int   m_total;

    descpt_feeder dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .layer1_num         (layer1_num),
        .layer2_num         (layer2_num),
        .descriptor_request (descriptor_request),
        .descriptor_valid   (descriptor_valid),
        .image_R_C_D_0      (image_R_C_D_0),
        .image_R_C_D_1      (image_R_C_D_1),
        .image_R_C_D_2      (image_R_C_D_2),
        .image_R_C_D_3      (image_R_C_D_3),
        .slot_valid         (slot_valid),
        .exhausted          (exhausted),
        .busy               (busy),
        .mem_en             (mem_en),
        .mem_addr           (mem_addr),
        .mem_dout           (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DESC_W-1:0] memf(input int a);
        logic [DESC_W-1:0] v;
        v = '0;
        v[31:0]          = 32'hD000_0000 ^ 32'(a);
        v[200 +: 32]     = 32'(a * 7 + 3);
        v[DESC_W-1 -: 32] = ~32'(a);
        return v;
    endfunction

    // Sync-read descriptor memory, one cycle latency.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= memf(int'(mem_addr));
    end

    task automatic chk(input string tag, input logic [DESC_W-1:0] obs, input logic [DESC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_next();
        exp_t e;
        e = '0;
        if (m_base >= m_total) begin
            e.exh = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_base + k < m_total) begin
                    e.d[k]  = memf(m_base + k);
                    e.sv[k] = 1'b1;
                end
            end
            m_base += 4;
        end
        return e;
    endfunction

    task automatic do_start(input int l1, input int l2);
        start      = 1'b1;
        layer1_num = CNT_W'(l1);
        layer2_num = CNT_W'(l2);
        @(negedge clk);
        start   = 1'b0;
        m_total = l1 + l2;
        m_base  = 0;
        chki("start_clears_exhausted", int'(exhausted), 0);
    endtask

    // Called at a negedge with the DUT in WAIT_REQ (off=1) or in VALID with request held (off=2).
    task automatic fetch(input int off, input bit hold, input bit chk_stable);
        exp_t e;
        exp_t got;
        int   n;
        int   lat;
        int   b;
        bit   seen;
        logic [3:0][DESC_W-1:0] obs;
        b = m_base;
        e = model_next();
        sb.push_back(e);
        lat = e.exh ? off : off + 5;
        descriptor_request = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (!e.exh && n >= off && n < off + 4) begin
                chki($sformatf("mem_addr[%0d]", n - off), int'(mem_addr), b + n - off);
                chki($sformatf("mem_en[%0d]", n - off), int'(mem_en), int'(b + n - off < m_total));
                chki("busy_in_fetch", int'(busy), 1);
            end
            if (chk_stable && n == off + 1) begin
                chk("slot0_stable", image_R_C_D_0, last_exp.d[0]);
            end
            if (descriptor_valid) seen = 1'b1;
        end
        chki("valid_latency", n, lat);
        got = sb.pop_front();
        obs = {image_R_C_D_3, image_R_C_D_2, image_R_C_D_1, image_R_C_D_0};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("slot%0d_data", k), obs[k], got.d[k]);
        end
        chki("slot_valid", int'(slot_valid), int'(got.sv));
        chki("exhausted", int'(exhausted), int'(got.exh));
        chki("busy_at_valid", int'(busy), 0);
        last_exp = got;
        if (!hold) begin
            descriptor_request = 1'b0;
            @(negedge clk);
            chki("valid_pulse_width", int'(descriptor_valid), 0);
        end
    endtask

    initial begin
        int cnt;
        rst_n              = 1'b0;
        start              = 1'b0;
        layer1_num         = '0;
        layer2_num         = '0;
        descriptor_request = 1'b0;
        last_exp           = '0;
        m_base             = 0;
        m_total            = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chki("rst_valid", int'(descriptor_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_mem_en", int'(mem_en), 0);
        chki("rst_mem_addr", int'(mem_addr), 0);
        chki("rst_slot_valid", int'(slot_valid), 0);
        chki("rst_exhausted", int'(exhausted), 0);
        chk("rst_slot0", image_R_C_D_0, '0);
        chk("rst_slot3", image_R_C_D_3, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores requests
        descriptor_request = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || descriptor_valid) cnt++;
        end
        chki("idle_ignores_request", cnt, 0);
        descriptor_request = 1'b0;
        @(negedge clk);

        // 5+3: two full groups
        do_start(5, 3);
        fetch(1, 1'b0, 1'b0);
        fetch(1, 1'b0, 1'b1);

        // 4+2: partial second group
        do_start(4, 2);
        fetch(1, 1'b0, 1'b0);
        fetch(1, 1'b0, 1'b0);

        // total 4: second request finds nothing left
        do_start(3, 1);
        fetch(1, 1'b0, 1'b0);
        fetch(1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chki("exhausted_sticky", int'(exhausted), 1);
        do_start(3, 1);

        // start during RD2 aborts the fetch
        do_start(5, 3);
        descriptor_request = 1'b1;
        repeat (3) @(negedge clk);
        start              = 1'b1;
        descriptor_request = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (descriptor_valid) cnt++;
        end
        chki("abort_no_valid", cnt, 0);
        chk("abort_slot0_captured", image_R_C_D_0, memf(0));
        chk("abort_slot1_kept", image_R_C_D_1, last_exp.d[1]);
        m_base = 0;
        fetch(1, 1'b0, 1'b0);

        // Reset asserted during RD1
        do_start(5, 3);
        descriptor_request = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chki("midrst_busy", int'(busy), 0);
        chki("midrst_mem_en", int'(mem_en), 0);
        chki("midrst_mem_addr", int'(mem_addr), 0);
        chki("midrst_slot_valid", int'(slot_valid), 0);
        chk("midrst_slot0", image_R_C_D_0, '0);
        chki("midrst_valid", int'(descriptor_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || descriptor_valid) cnt++;
        end
        chki("post_rst_ignores_request", cnt, 0);
        descriptor_request = 1'b0;
        @(negedge clk);
        last_exp = '0;
        do_start(5, 3);
        fetch(1, 1'b0, 1'b0);

        // Request held high past valid: back-to-back fetch
        do_start(5, 3);
        fetch(1, 1'b1, 1'b0);
        fetch(2, 1'b0, 1'b1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (descriptor_valid) cnt++;
        end
        chki("no_extra_valid", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
